// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MWAIT  = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  localparam int unsigned RR_USED_RM = 0;
  localparam int unsigned RR_USED_RN = 1;
  localparam int unsigned RR_USED_RD = 2;

  // Control-word bit that marks a load in the execute stage.
  localparam int unsigned CTRL_LOADS_BIT = 8;

  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// Load-use detector: matches the execute-stage load destination against
// the register numbers read by the read-register stage.
module hazard_cmp
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [2:0] i_num_Rm,
  input  logic [2:0] i_num_Rn,
  input  logic [2:0] i_num_Rd,
  input  logic [2:0] i_used,
  input  logic [2:0] i_ex_num_Rd,
  input  logic       i_ex_loads,
  output logic       o_hazard
);

  logic w_hit_rm;
  logic w_hit_rn;
  logic w_hit_rd;

  always_comb begin
    w_hit_rm = i_used[RR_USED_RM] & (i_num_Rm == i_ex_num_Rd);
    w_hit_rn = i_used[RR_USED_RN] & (i_num_Rn == i_ex_num_Rd);
    w_hit_rd = i_used[RR_USED_RD] & (i_num_Rd == i_ex_num_Rd);
    o_hazard = i_ex_loads & (w_hit_rm | w_hit_rn | w_hit_rd);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stage sequencer: load-use stalls, memory freeze, branch squash.
// Define HAZARD_PERFCNT_EN to add the stall_cycles/flush_events counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rr_num_Rm,
  input  logic [2:0]  rr_num_Rn,
  input  logic [2:0]  rr_num_Rd,
  input  logic [2:0]  rr_used,
  input  logic [2:0]  ex_num_Rd,
  input  logic        ex_loads,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        update_if,
  output logic        update_rr,
  output logic        update_ex,
  output logic        update_mem,
  output logic        bubble_ex,
  output logic        flush_rr,
`ifdef HAZARD_PERFCNT_EN
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events,
`endif
  output logic        stall
);

  localparam logic [CNT_W-1:0] LSTALL_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_branch_pending;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pend_nxt;
  logic             w_hazard;
  logic             w_memwait;
  logic             w_take_flush;
  logic             w_uif, w_urr, w_uex, w_umem, w_bub, w_flr;
  logic [CNT_W-1:0] w_cnt_dec;

  hazard_cmp u_hazard_cmp (
    .i_num_Rm    (rr_num_Rm),
    .i_num_Rn    (rr_num_Rn),
    .i_num_Rd    (rr_num_Rd),
    .i_used      (rr_used),
    .i_ex_num_Rd (ex_num_Rd),
    .i_ex_loads  (ex_loads),
    .o_hazard    (w_hazard)
  );

  always_comb begin
    w_memwait    = mem_req & ~mem_ready;
    w_cnt_dec    = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pend_nxt   = r_branch_pending;
    w_take_flush = 1'b0;
    w_uif        = 1'b0;
    w_urr        = 1'b0;
    w_uex        = 1'b0;
    w_umem       = 1'b0;
    w_bub        = 1'b0;
    w_flr        = 1'b0;

    unique case (r_state)
      RUN, LSTALL: begin
        if (w_memwait) begin
          w_state_nxt = MWAIT;
          w_pend_nxt  = r_branch_pending | branch_taken;
        end else if (branch_taken) begin
          w_take_flush = 1'b1;
        end else if ((r_state == LSTALL) || w_hazard) begin
          w_uex  = 1'b1;
          w_umem = 1'b1;
          w_bub  = 1'b1;
          if (r_state == RUN) begin
            w_cnt_nxt   = LSTALL_LOAD;
            w_state_nxt = (LSTALL_LOAD != '0) ? LSTALL : RUN;
          end else begin
            w_cnt_nxt   = w_cnt_dec;
            w_state_nxt = (w_cnt_dec == '0) ? RUN : LSTALL;
          end
        end else begin
          {w_uif, w_urr, w_uex, w_umem} = '1;
        end
      end
      MWAIT: begin
        if (w_memwait) begin
          w_pend_nxt = r_branch_pending | branch_taken;
        end else if (r_branch_pending || branch_taken) begin
          w_take_flush = 1'b1;
        end else begin
          {w_uif, w_urr, w_uex, w_umem} = '1;
          w_state_nxt = (r_cnt != '0) ? LSTALL : RUN;
        end
      end
      FLUSH: begin
        // A freeze mid-flush re-arms the full flush once memory completes.
        if (w_memwait) begin
          w_state_nxt = MWAIT;
          w_pend_nxt  = 1'b1;
        end else if (branch_taken) begin
          w_take_flush = 1'b1;
        end else begin
          {w_uif, w_urr, w_uex, w_umem} = '1;
          w_flr       = 1'b1;
          w_cnt_nxt   = w_cnt_dec;
          w_state_nxt = (w_cnt_dec == '0) ? RUN : FLUSH;
        end
      end
      default: w_state_nxt = RUN;
    endcase

    if (w_take_flush) begin
      {w_uif, w_urr, w_uex, w_umem} = '1;
      w_flr       = 1'b1;
      w_bub       = 1'b1;
      w_pend_nxt  = 1'b0;
      w_cnt_nxt   = FLUSH_LOAD;
      w_state_nxt = (FLUSH_LOAD != '0) ? FLUSH : RUN;
    end
  end

  always_comb begin
    update_if  = rst & w_uif;
    update_rr  = rst & w_urr;
    update_ex  = rst & w_uex;
    update_mem = rst & w_umem;
    bubble_ex  = ~rst | w_bub;
    flush_rr   = ~rst | w_flr;
    stall      = ~update_if;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= RUN;
      r_cnt            <= '0;
      r_branch_pending <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      r_branch_pending <= w_pend_nxt;
    end
  end

`ifdef HAZARD_PERFCNT_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_events;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 16'd1;
      if (w_take_flush && (r_flush_events != '1))
        r_flush_events <= r_flush_events + 16'd1;
    end
  end

  always_comb begin
    stall_cycles = r_stall_cycles;
    flush_events = r_flush_events;
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controllers (1- and 3-cycle load stalls) share
// directed stimulus; expected output vectors are queued and checked per cycle.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rr_num_Rm, rr_num_Rn, rr_num_Rd, rr_used, ex_num_Rd;
  logic       ex_loads, mem_req, mem_ready, branch_taken;

  logic u1_if, u1_rr, u1_ex, u1_mem, b1, f1, s1;
  logic u3_if, u3_rr, u3_ex, u3_mem, b3, f3, s3;

  // {update_if, update_rr, update_ex, update_mem, bubble_ex, flush_rr, stall}
  localparam logic [6:0] RSTV = 7'b0000111;
  localparam logic [6:0] NRM  = 7'b1111000;
  localparam logic [6:0] HZ   = 7'b0011101;
  localparam logic [6:0] FZ   = 7'b0000001;
  localparam logic [6:0] BRV  = 7'b1111110;
  localparam logic [6:0] FLV  = 7'b1111010;

  typedef struct {
    int         id;
    logic [6:0] e1;
    logic [6:0] e3;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_vec    = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst), .rr_num_Rm(rr_num_Rm), .rr_num_Rn(rr_num_Rn),
    .rr_num_Rd(rr_num_Rd), .rr_used(rr_used), .ex_num_Rd(ex_num_Rd),
    .ex_loads(ex_loads), .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .update_if(u1_if), .update_rr(u1_rr),
    .update_ex(u1_ex), .update_mem(u1_mem), .bubble_ex(b1), .flush_rr(f1),
    .stall(s1)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) u_dut3 (
    .clk(clk), .rst(rst), .rr_num_Rm(rr_num_Rm), .rr_num_Rn(rr_num_Rn),
    .rr_num_Rd(rr_num_Rd), .rr_used(rr_used), .ex_num_Rd(ex_num_Rd),
    .ex_loads(ex_loads), .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .update_if(u3_if), .update_rr(u3_rr),
    .update_ex(u3_ex), .update_mem(u3_mem), .bubble_ex(b3), .flush_rr(f3),
    .stall(s3)
  );

  logic [6:0] act1, act3;
  assign act1 = {u1_if, u1_rr, u1_ex, u1_mem, b1, f1, s1};
  assign act3 = {u3_if, u3_rr, u3_ex, u3_mem, b3, f3, s3};

  task automatic cyc(input logic a_rst, input logic [2:0] a_rm, input logic [2:0] a_rn,
                     input logic [2:0] a_rd, input logic [2:0] a_used,
                     input logic [2:0] a_exrd, input logic a_ld, input logic a_req,
                     input logic a_rdy, input logic a_br,
                     input logic [6:0] a_e1, input logic [6:0] a_e3);
    exp_t e;
    @(posedge clk);
    #1;
    rst = a_rst; rr_num_Rm = a_rm; rr_num_Rn = a_rn; rr_num_Rd = a_rd;
    rr_used = a_used; ex_num_Rd = a_exrd; ex_loads = a_ld;
    mem_req = a_req; mem_ready = a_rdy; branch_taken = a_br;
    e.id = n_vec; e.e1 = a_e1; e.e3 = a_e3;
    q.push_back(e);
    n_vec++;
  endtask

  task automatic idle(input logic [6:0] a_e1, input logic [6:0] a_e3);
    cyc(1'b1, 3'd0, 3'd0, 3'd0, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, a_e1, a_e3);
  endtask

  task automatic mem(input logic a_rdy, input logic a_br, input logic [6:0] a_e1,
                     input logic [6:0] a_e3);
    cyc(1'b1, 3'd0, 3'd0, 3'd0, 3'b000, 3'd0, 1'b0, 1'b1, a_rdy, a_br, a_e1, a_e3);
  endtask

  // Load of R3 in execute, read-register reads Rn=R3.
  task automatic haz_rn3(input logic a_br, input logic [6:0] a_e1, input logic [6:0] a_e3);
    cyc(1'b1, 3'd0, 3'd3, 3'd0, 3'b010, 3'd3, 1'b1, 1'b0, 1'b0, a_br, a_e1, a_e3);
  endtask

  task automatic br(input logic [6:0] a_e1, input logic [6:0] a_e3);
    cyc(1'b1, 3'd0, 3'd0, 3'd0, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, a_e1, a_e3);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (act1 !== e.e1) begin
          n_fail++;
          $display("FAIL vec%0d lsc1: got %b required %b", e.id, act1, e.e1);
        end
        n_checks++;
        if (act3 !== e.e3) begin
          n_fail++;
          $display("FAIL vec%0d lsc3: got %b required %b", e.id, act3, e.e3);
        end
      end
    end
  end

  initial begin : driver
    int waited;
    rst = 1'b0; rr_num_Rm = '0; rr_num_Rn = '0; rr_num_Rd = '0; rr_used = '0;
    ex_num_Rd = '0; ex_loads = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    branch_taken = 1'b0;

    // reset state
    repeat (2) cyc(1'b0, 3'd0, 3'd0, 3'd0, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, RSTV, RSTV);
    idle(NRM, NRM);

    // load-use on Rn
    haz_rn3(1'b0, HZ, HZ);
    idle(NRM, HZ); idle(NRM, HZ); idle(NRM, NRM);

    // no hazard: nothing read, no match, or not a load
    cyc(1'b1, 3'd0, 3'd3, 3'd0, 3'b000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, NRM, NRM);
    cyc(1'b1, 3'd1, 3'd2, 3'd4, 3'b111, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, NRM, NRM);
    cyc(1'b1, 3'd3, 3'd3, 3'd3, 3'b111, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, NRM, NRM);

    // memory wait 3 cycles then ready
    repeat (3) mem(1'b0, 1'b0, FZ, FZ);
    mem(1'b1, 1'b0, NRM, NRM);
    idle(NRM, NRM);

    // taken branch in RUN
    br(BRV, BRV); idle(FLV, FLV); idle(NRM, NRM);

    // branch during MWAIT, ready two cycles later
    mem(1'b0, 1'b0, FZ, FZ); mem(1'b0, 1'b1, FZ, FZ); mem(1'b0, 1'b0, FZ, FZ);
    mem(1'b1, 1'b0, BRV, BRV); idle(FLV, FLV); idle(NRM, NRM);

    // reset while the 3-cycle controller is in LSTALL
    haz_rn3(1'b0, HZ, HZ);
    cyc(1'b0, 3'd0, 3'd0, 3'd0, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, RSTV, RSTV);
    idle(NRM, NRM); idle(NRM, NRM);

    // branch beats hazard
    haz_rn3(1'b1, BRV, BRV); idle(FLV, FLV); idle(NRM, NRM);

    // memwait beats branch; branch applied on ready
    mem(1'b0, 1'b1, FZ, FZ); mem(1'b1, 1'b0, BRV, BRV); idle(FLV, FLV); idle(NRM, NRM);

    // memwait preempts LSTALL; remaining count resumes after ready
    haz_rn3(1'b0, HZ, HZ);
    mem(1'b0, 1'b0, FZ, FZ); mem(1'b1, 1'b0, NRM, NRM);
    idle(NRM, HZ); idle(NRM, HZ); idle(NRM, NRM);

    // memwait during FLUSH re-arms the flush
    br(BRV, BRV); mem(1'b0, 1'b0, FZ, FZ); mem(1'b1, 1'b0, BRV, BRV);
    idle(FLV, FLV); idle(NRM, NRM);

    // branch abandons LSTALL
    haz_rn3(1'b0, HZ, HZ); br(BRV, BRV); idle(FLV, FLV); idle(NRM, NRM);

    // Rd (store source) match; Rm match masked by rr_used
    cyc(1'b1, 3'd6, 3'd1, 3'd2, 3'b110, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, NRM, NRM);
    cyc(1'b1, 3'd0, 3'd1, 3'd6, 3'b100, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, HZ, HZ);
    idle(NRM, HZ); idle(NRM, HZ); idle(NRM, NRM);

    // Rm match on R0
    cyc(1'b1, 3'd0, 3'd5, 3'd5, 3'b001, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, HZ, HZ);
    idle(NRM, HZ); idle(NRM, HZ); idle(NRM, NRM);

    // branch inside FLUSH reloads the count
    br(BRV, BRV); br(BRV, BRV); idle(FLV, FLV); idle(NRM, NRM);

    waited = 0;
    while (q.size() > 0 && waited < 5) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
